pkt_queue_ctrl: RTL and testbench
=================================

PKT_QUEUE_CTRL -- requirements
Module: pkt_queue_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DWIDTH 72, processor data width; AWIDTH 10, processor address width; NSLOT 4, descriptor ring depth (power of 2, ≥2); PW = AWIDTH-2, packet-buffer address width.
REQ-002 Reset is reset_n, synchronous, active-low; clock is clk.
REQ-003 Ports (name direction width meaning):
- clk in 1 clock
- reset_n in 1 sync active-low reset
- pc_en in 1 block enable; low behaves as reset
- i_we in 1 ingress word valid
- i_ctrl in 8 ingress control byte
- tail_addr in PW ingress write address of the current word
- head_addr in PW egress read address
- wea in 1 processor write strobe
- addra in AWIDTH processor address; bit AWIDTH-1 selects this block
- dina in DWIDTH processor write data
- douta out DWIDTH processor read data, registered
- stall out 1 ingress back-pressure
- stop_tx out 1 egress hold
- fifo_sel out 1 1 = egress from packet buffer, 0 = processor side
- drop_packet out 1 one-cycle drop pulse
- skip_addr out PW head reload address, valid with drop_packet

Function
REQ-004 SOP SHALL be detected as i_we & i_ctrl==8'hFF & prev_ctrl!=8'hFF, capturing tail_addr into open_start and setting sop_open. prev_ctrl updates only on i_we.
REQ-005 EOP SHALL be detected as i_we & i_ctrl!=0 & prev_ctrl==0 & sop_open; it pushes descriptor {start=open_start, end=tail_addr, drop=0} at wr_ptr and clears sop_open.
REQ-006 Ring SHALL use three pointers, each clog2(NSLOT)+1 bits and wrapping modulo 2·NSLOT: wr_ptr (push), pr_ptr (next to process), tx_ptr (oldest). Invariant: tx_ptr ≤ pr_ptr ≤ wr_ptr in ring order.
- count = wr_ptr - tx_ptr
- full = count==NSLOT
REQ-007 stall SHALL equal full, combinationally.
- EOP while full: descriptor discarded, sticky ovf set, pointers unchanged.
- Push and tx pop in the same cycle: both take effect.
REQ-008 Register map at addra[AWIDTH-1]=1, offset addra[3:0]; douta SHALL be updated one cycle after the address, and be 0 for unmapped offsets or addra[AWIDTH-1]=0:
- 0x0 STATUS RO: {ovf, sop_open, pending=wr_ptr-pr_ptr, count}
- 0x1 CUR_START RO: start of descriptor at pr_ptr, 0 if pending==0
- 0x2 CUR_END RO: end of descriptor at pr_ptr, 0 if pending==0
- 0x3 VERDICT WO: bit0=drop, bit1=commit
- 0x4 OVF_CLR W1C on bit0
REQ-009 A VERDICT write with commit=1 and pending≠0 SHALL latch drop into entry pr_ptr and increment pr_ptr. It is ignored when pending==0. It may coincide with a push.
REQ-010 Egress FSM states:
- IDLE: fifo_sel=1, drop_packet=0. stop_tx=1 iff head_addr==guard, where guard = start[tx_ptr] if count≠0, else open_start if sop_open, else tail_addr. If tx_ptr≠pr_ptr and the entry is not dropped → FWD. If tx_ptr≠pr_ptr and the entry is dropped → DROP.
- FWD: stop_tx=0, fifo_sel=1. When head_addr==end[tx_ptr], increment tx_ptr → IDLE.
- DROP: single cycle. drop_packet=1, skip_addr=end[tx_ptr]+1 (mod 2^PW), stop_tx=1, fifo_sel=0. Increment tx_ptr → IDLE.
REQ-011 All address compares and arithmetic SHALL be PW-bit modulo; packets wrapping past address 2^PW-1 SHALL be handled without special cases.
REQ-012 Outputs other than stall, stop_tx, and douta SHALL be registered.

Reset
REQ-013 On reset_n=0 or pc_en=0 at a clk edge, the block SHALL clear:
- pointers, ovf, sop_open, prev_ctrl, open_start, all descriptors
- FSM state to IDLE
- douta, drop_packet, skip_addr to 0
- fifo_sel to 1
REQ-014 A reset mid-packet or mid-FWD SHALL discard all descriptors; no drop pulse is emitted.

Verification
REQ-015 SOP at tail 0x010, EOP at tail 0x01F → STATUS count=1, pending=1; CUR_START=0x010 and CUR_END=0x01F one cycle after their reads; stop_tx=1 while head_addr=0x010.
REQ-016 VERDICT=0b10 for that packet → FSM enters FWD; stop_tx=0; tx_ptr advances the cycle head_addr=0x01F; count=0.
REQ-017 VERDICT=0b11 → drop_packet high for exactly one cycle, skip_addr=0x020, fifo_sel=0 that cycle; count decrements.
REQ-018 NSLOT=4: push 4 packets → stall=1; a 5th EOP sets ovf with count=4; OVF_CLR write 1 → ovf=0.
REQ-019 Packet with start 0x0FC, end 0x003 (PW=8) forwarded → FWD exits at head_addr=0x003; drop of the same packet gives skip_addr=0x004.
REQ-020 Commit while pending=0 → no state change; reset_n=0 during FWD → next cycle count=0, fifo_sel=1, drop_packet=0.

Source files
------------

// File: rtl/pkt_queue_ctrl_if.sv
// Ingress, egress-head and processor-port bundle for pkt_queue_ctrl.
// The slave modport is the queue controller and the master modport is whatever drives it.
interface pkt_queue_ctrl_if #(
   parameter int DWIDTH = 72,
   parameter int AWIDTH = 10
) ();
   localparam int PW = AWIDTH - 2;

   logic              i_we;
   logic [7:0]        i_ctrl;
   logic [PW-1:0]     tail_addr;
   logic [PW-1:0]     head_addr;
   logic              wea;
   logic [AWIDTH-1:0] addra;
   logic [DWIDTH-1:0] dina;
   logic [DWIDTH-1:0] douta;
   logic              stall;
   logic              stop_tx;
   logic              fifo_sel;
   logic              drop_packet;
   logic [PW-1:0]     skip_addr;

   modport slave (
      input  i_we, i_ctrl, tail_addr, head_addr, wea, addra, dina,
      output douta, stall, stop_tx, fifo_sel, drop_packet, skip_addr
   );

   modport master (
      output i_we, i_ctrl, tail_addr, head_addr, wea, addra, dina,
      input  douta, stall, stop_tx, fifo_sel, drop_packet, skip_addr
   );
endinterface

// File: rtl/pkt_queue_ctrl.sv
// Packet descriptor ring: EOP pushes, processor verdicts, egress forwards or drops in order.
// douta is one cycle behind addra; stall rises combinationally while the ring holds NSLOT descriptors.
module pkt_queue_ctrl #(
   parameter int DWIDTH = 72,
   parameter int AWIDTH = 10,
   parameter int NSLOT  = 4
) (
   input logic             clk,
   input logic             reset_n,
   input logic             pc_en,
   pkt_queue_ctrl_if.slave bus
);
   localparam int PW   = AWIDTH - 2;
   localparam int IW   = $clog2(NSLOT);
   localparam int PTRW = IW + 1;
   localparam int SW   = 2 * PTRW + 2;

   typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

   state_t            state, state_nxt;
   logic [PTRW-1:0]   wr_ptr, pr_ptr, tx_ptr;
   logic [PTRW-1:0]   count, pending;
   logic [PW-1:0]     start_q [NSLOT];
   logic [PW-1:0]     end_q   [NSLOT];
   logic [NSLOT-1:0]  drop_q;
   logic [7:0]        prev_ctrl;
   logic              sop_open, ovf;
   logic [PW-1:0]     open_start;
   logic              clr, full, sop, eop, push;
   logic              reg_sel, verdict_ok, ovf_clr;
   logic [3:0]        offset;
   logic [IW-1:0]     wr_idx, pr_idx, tx_idx;
   logic [PW-1:0]     guard;
   logic              stop_tx_c, tx_pop;
   logic [DWIDTH-1:0] rd_dat;
   logic [DWIDTH-1:0] douta_q;
   logic              drop_packet_q, fifo_sel_q;
   logic [PW-1:0]     skip_addr_q;

   // pc_en low is treated exactly like reset
   assign clr     = !reset_n || !pc_en;
   assign wr_idx  = wr_ptr[IW-1:0];
   assign pr_idx  = pr_ptr[IW-1:0];
   assign tx_idx  = tx_ptr[IW-1:0];
   assign count   = wr_ptr - tx_ptr;
   assign pending = wr_ptr - pr_ptr;
   assign full    = (count == PTRW'(NSLOT));

   assign sop  = bus.i_we && (bus.i_ctrl == 8'hFF) && (prev_ctrl != 8'hFF);
   assign eop  = bus.i_we && (bus.i_ctrl != 8'h00) && (prev_ctrl == 8'h00) && sop_open;
   assign push = eop && !full;

   assign reg_sel    = bus.addra[AWIDTH-1];
   assign offset     = bus.addra[3:0];
   assign verdict_ok = bus.wea && reg_sel && (offset == 4'h3) && bus.dina[1] && (pending != '0);
   assign ovf_clr    = bus.wea && reg_sel && (offset == 4'h4) && bus.dina[0];

   always_comb begin
      guard = bus.tail_addr;
      if (count != '0)
         guard = start_q[tx_idx];
      else if (sop_open)
         guard = open_start;
   end

   always_comb begin
      state_nxt = state;
      stop_tx_c = 1'b1;
      tx_pop    = 1'b0;
      case (state)
         S_IDLE: begin
            stop_tx_c = (bus.head_addr == guard);
            if (tx_ptr != pr_ptr)
               state_nxt = drop_q[tx_idx] ? S_DROP : S_FWD;
         end
         S_FWD: begin
            stop_tx_c = 1'b0;
            if (bus.head_addr == end_q[tx_idx]) begin
               tx_pop    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_DROP: begin
            tx_pop    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_dat = '0;
      if (reg_sel) begin
         case (offset)
            4'h0: rd_dat[SW-1:0] = {ovf, sop_open, pending, count};
            4'h1: if (pending != '0) rd_dat[PW-1:0] = start_q[pr_idx];
            4'h2: if (pending != '0) rd_dat[PW-1:0] = end_q[pr_idx];
            default: rd_dat = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr     <= '0;
         pr_ptr     <= '0;
         tx_ptr     <= '0;
         prev_ctrl  <= '0;
         sop_open   <= 1'b0;
         open_start <= '0;
         ovf        <= 1'b0;
         drop_q     <= '0;
         for (int i = 0; i < NSLOT; i++) begin
            start_q[i] <= '0;
            end_q[i]   <= '0;
         end
      end else begin
         if (bus.i_we)
            prev_ctrl <= bus.i_ctrl;
         if (eop)
            sop_open <= 1'b0;
         // A word that both closes one packet and opens the next leaves the new one open
         if (sop) begin
            sop_open   <= 1'b1;
            open_start <= bus.tail_addr;
         end
         if (push) begin
            start_q[wr_idx] <= open_start;
            end_q[wr_idx]   <= bus.tail_addr;
            drop_q[wr_idx]  <= 1'b0;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (verdict_ok) begin
            drop_q[pr_idx] <= bus.dina[0];
            pr_ptr         <= pr_ptr + 1'b1;
         end
         if (tx_pop)
            tx_ptr <= tx_ptr + 1'b1;
         if (ovf_clr)
            ovf <= 1'b0;
         if (eop && full)
            ovf <= 1'b1;
      end
   end

   // Egress outputs are registered from next_state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (clr) begin
         state         <= S_IDLE;
         douta_q       <= '0;
         drop_packet_q <= 1'b0;
         fifo_sel_q    <= 1'b1;
         skip_addr_q   <= '0;
      end else begin
         state         <= state_nxt;
         douta_q       <= rd_dat;
         drop_packet_q <= (state_nxt == S_DROP);
         fifo_sel_q    <= (state_nxt != S_DROP);
         if (state_nxt == S_DROP)
            skip_addr_q <= end_q[tx_idx] + 1'b1;
      end
   end

   assign bus.douta       = douta_q;
   assign bus.stall       = full;
   assign bus.stop_tx     = stop_tx_c;
   assign bus.fifo_sel    = fifo_sel_q;
   assign bus.drop_packet = drop_packet_q;
   assign bus.skip_addr   = skip_addr_q;
endmodule

// File: tb/tb_pkt_queue_ctrl.sv
// Directed bench for pkt_queue_ctrl: push, verdict, forward, drop, overflow, wrap and reset cases.
module tb_pkt_queue_ctrl;
   localparam int DWIDTH = 72;
   localparam int AWIDTH = 10;
   localparam int NSLOT  = 4;
   localparam int PW     = AWIDTH - 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic pc_en   = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   pkt_queue_ctrl_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) bus ();

   pkt_queue_ctrl #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .NSLOT(NSLOT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .pc_en   (pc_en),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [DWIDTH-1:0] obs, input logic [DWIDTH-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic word(input logic [7:0] ctrl, input logic [PW-1:0] addr);
      bus.i_we      = 1'b1;
      bus.i_ctrl    = ctrl;
      bus.tail_addr = addr;
      tick();
      bus.i_we      = 1'b0;
   endtask

   task automatic packet(input logic [PW-1:0] s, input logic [PW-1:0] e);
      word(8'hFF, s);
      word(8'h00, s + PW'(1));
      word(8'h01, e);
   endtask

   task automatic rd(input logic [3:0] off, output logic [DWIDTH-1:0] v);
      bus.addra = {1'b1, {(AWIDTH-5){1'b0}}, off};
      bus.wea   = 1'b0;
      tick();
      v         = bus.douta;
      bus.addra = '0;
   endtask

   task automatic wr(input logic [3:0] off, input logic [1:0] d);
      bus.addra = {1'b1, {(AWIDTH-5){1'b0}}, off};
      bus.dina  = DWIDTH'(d);
      bus.wea   = 1'b1;
      tick();
      bus.wea   = 1'b0;
      bus.addra = '0;
      bus.dina  = '0;
   endtask

   task automatic status_is(input string tag, input logic [7:0] exp);
      logic [DWIDTH-1:0] v;
      rd(4'h0, v);
      chk(tag, v, DWIDTH'(exp));
   endtask

   initial begin
      logic [DWIDTH-1:0] v;
      logic [PW-1:0]     s;
      bus.i_we = 1'b0; bus.i_ctrl = '0; bus.tail_addr = '0; bus.head_addr = '0;
      bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
      tick(); tick();
      reset_n = 1'b1;

      // reset state
      chk("rst_douta", bus.douta, 0);
      chk("rst_drop", bus.drop_packet, 0);
      chk("rst_fifo_sel", bus.fifo_sel, 1);
      chk("rst_skip", bus.skip_addr, 0);
      chk("rst_stall", bus.stall, 0);
      chk("rst_stop_tx", bus.stop_tx, 1);
      status_is("rst_status", 8'h00);

      // one packet 0x10..0x1F, no verdict yet
      bus.head_addr = 8'h10;
      word(8'hFF, 8'h10);
      status_is("sop_status", 8'h40);
      word(8'h00, 8'h11);
      word(8'h01, 8'h1F);
      status_is("eop_status", 8'h09);
      rd(4'h1, v); chk("cur_start", v, 8'h10);
      rd(4'h2, v); chk("cur_end", v, 8'h1F);
      chk("guard_stop", bus.stop_tx, 1);
      bus.addra = '0; tick();
      chk("unmapped_rd", bus.douta, 0);
      bus.head_addr = 8'h11; #1;
      chk("guard_pass", bus.stop_tx, 0);
      bus.head_addr = 8'h10; #1;

      // commit and forward
      wr(4'h3, 2'b10);
      chk("commit_idle_stop", bus.stop_tx, 1);
      tick();
      chk("fwd_stop", bus.stop_tx, 0);
      chk("fwd_fifo_sel", bus.fifo_sel, 1);
      status_is("fwd_status", 8'h01);
      bus.head_addr = 8'h1F; #1;
      chk("fwd_end_stop", bus.stop_tx, 0);
      tick();
      status_is("fwd_done_status", 8'h00);
      chk("tail_guard_stop", bus.stop_tx, 1);

      // drop verdict
      packet(8'h10, 8'h1F);
      status_is("drop_pre_status", 8'h09);
      wr(4'h3, 2'b11);
      chk("drop_not_yet", bus.drop_packet, 0);
      tick();
      chk("drop_pulse", bus.drop_packet, 1);
      chk("drop_fifo_sel", bus.fifo_sel, 0);
      chk("drop_skip", bus.skip_addr, 8'h20);
      chk("drop_stop", bus.stop_tx, 1);
      tick();
      chk("drop_pulse_end", bus.drop_packet, 0);
      chk("drop_fifo_sel_end", bus.fifo_sel, 1);
      status_is("drop_post_status", 8'h00);

      // fill ring, overflow, clear
      for (int i = 0; i < NSLOT; i++) begin
         s = PW'(8'h40 + 16 * i);
         packet(s, s + PW'(15));
         if (i == NSLOT - 2) chk("stall_below_full", bus.stall, 0);
      end
      chk("stall_full", bus.stall, 1);
      packet(8'h80, 8'h8F);
      status_is("ovf_status", 8'hA4);
      chk("stall_ovf", bus.stall, 1);
      wr(4'h4, 2'b01);
      status_is("ovf_clr_status", 8'h24);

      // pc_en low clears everything
      pc_en = 1'b0; tick(); pc_en = 1'b1;
      status_is("pc_en_status", 8'h00);
      chk("pc_en_stall", bus.stall, 0);

      // packet wrapping past the top of the buffer
      bus.head_addr = 8'h80;
      packet(8'hFC, 8'h03);
      rd(4'h1, v); chk("wrap_start", v, 8'hFC);
      rd(4'h2, v); chk("wrap_end", v, 8'h03);
      bus.head_addr = 8'hFC;
      wr(4'h3, 2'b10);
      tick();
      chk("wrap_fwd_stop", bus.stop_tx, 0);
      bus.head_addr = 8'h00;
      status_is("wrap_fwd_mid", 8'h01);
      bus.head_addr = 8'h03;
      tick();
      status_is("wrap_fwd_done", 8'h00);
      packet(8'hFC, 8'h03);
      wr(4'h3, 2'b11);
      tick();
      chk("wrap_drop_pulse", bus.drop_packet, 1);
      chk("wrap_drop_skip", bus.skip_addr, 8'h04);
      tick();

      // commit with nothing pending, then reset mid-forward
      status_is("idle_commit_pre", 8'h00);
      wr(4'h3, 2'b10);
      status_is("idle_commit_post", 8'h00);
      chk("idle_commit_drop", bus.drop_packet, 0);
      packet(8'h50, 8'h5F);
      bus.head_addr = 8'h50;
      wr(4'h3, 2'b10);
      tick();
      chk("rst_fwd_stop", bus.stop_tx, 0);
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      chk("rst_fwd_fifo_sel", bus.fifo_sel, 1);
      chk("rst_fwd_drop", bus.drop_packet, 0);
      status_is("rst_fwd_status", 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      if (n_pass != n_total) $error("%0d checks did not match", n_total - n_pass);
      $finish;
   end
endmodule
